// File: rtl/m_dcache.sv
// rtl/m_dcache.sv - direct-mapped write-through no-write-allocate M-stage data cache
// Optional hit/miss counters are enabled with `define M_DCACHE_STATS_EN.
module m_dcache #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM_i,
  input  logic [2:0]  MemWriteM_i,
  input  logic [31:0] ALUResultM_i,
  input  logic [31:0] WriteDataM_i,
  output logic [31:0] ReadDataM_o,
  output logic        StallAllM_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
`ifdef M_DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
`endif
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int SB = $clog2(SETS);
  localparam int AW = WB + SB;
  localparam int TW = 30 - AW;
  localparam int CW = (WB > 0) ? WB : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(LINE_WORDS - 1);
  localparam logic [31:0]   LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q      [SETS];
  logic [31:0]     data_q     [SETS*LINE_WORDS];
  logic [31:0]     line_buf_q [LINE_WORDS];

  logic [SB-1:0] set_idx;
  logic [TW-1:0] addr_tag;
  logic [AW-1:0] word_idx;
  logic          is_store, is_load, hit, last_word, stall;
  logic [31:0]   refill_addr;
  logic [3:0]    st_be;
  logic [31:0]   st_wdata;

  assign set_idx     = ALUResultM_i[2+WB +: SB];
  assign addr_tag    = ALUResultM_i[31 -: TW];
  assign word_idx    = ALUResultM_i[2 +: AW];
  assign is_store    = (MemWriteM_i == 3'b001) || (MemWriteM_i == 3'b010) || (MemWriteM_i == 3'b011);
  assign is_load     = MemReadM_i && !is_store;
  assign hit         = valid_q[set_idx] && (tag_q[set_idx] == addr_tag);
  assign last_word   = (cnt_q == LAST_WORD);
  assign refill_addr = ({ALUResultM_i[31:2], 2'b00} & ~LINE_MASK) | {{(30-CW){1'b0}}, cnt_q, 2'b00};

  // Narrow stores are replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = WriteDataM_i;
    case (MemWriteM_i[1:0])
      2'b01: begin
        st_be    = 4'b0001 << ALUResultM_i[1:0];
        st_wdata = {4{WriteDataM_i[7:0]}};
      end
      2'b10: begin
        st_be    = ALUResultM_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WriteDataM_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    mem_be_o    = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (is_store) begin
          stall   = 1'b1;
          state_d = S_WRITE;
        end else if (is_load && !hit) begin
          stall   = 1'b1;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        stall      = 1'b1;
        mem_req_o  = 1'b1;
        mem_be_o   = 4'b1111;
        mem_addr_o = refill_addr;
        if (mem_ack_i && last_word) state_d = S_IDLE;
      end
      S_WRITE: begin
        stall       = !mem_ack_i;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {ALUResultM_i[31:2], 2'b00};
        mem_wdata_o = st_wdata;
        mem_be_o    = st_be;
        if (mem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign StallAllM_o = rst_n && stall;
  assign ReadDataM_o = rst_n ? data_q[word_idx] : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
      end else if (state_q == S_REFILL && mem_ack_i) begin
        cnt_q <= cnt_q + 1'b1;
        if (last_word) valid_q[set_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; validity alone decides whether their contents are used.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_REFILL && mem_ack_i) begin
        for (int i = 0; i < LINE_WORDS; i++) begin
          if (CW'(i) == cnt_q) line_buf_q[i] <= mem_rdata_i;
        end
        if (last_word) begin
          tag_q[set_idx] <= addr_tag;
          for (int i = 0; i < LINE_WORDS; i++) begin
            data_q[AW'(int'(set_idx) * LINE_WORDS + i)] <=
              (CW'(i) == cnt_q) ? mem_rdata_i : line_buf_q[i];
          end
        end
      end
      if (state_q == S_WRITE && mem_ack_i && hit) begin
        for (int b = 0; b < 4; b++) begin
          if (st_be[b]) data_q[word_idx][8*b +: 8] <= st_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef M_DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count_o  <= 32'h0;
      miss_count_o <= 32'h0;
    end else begin
      if (state_q == S_IDLE && is_load && hit) hit_count_o <= hit_count_o + 32'h1;
      if (state_q == S_IDLE && state_d == S_REFILL) miss_count_o <= miss_count_o + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_m_dcache.sv
// tb/tb_m_dcache.sv - vector table plus scoreboard bench for m_dcache
module tb_m_dcache;

  localparam int ACK_DELAY = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM_i;
  logic [2:0]  MemWriteM_i;
  logic [31:0] ALUResultM_i;
  logic [31:0] WriteDataM_i;
  logic [31:0] ReadDataM_o;
  logic        StallAllM_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  logic        ack_q = 1'b0;
  logic        late_ack = 1'b0;
  logic        ack_next = 1'b0;
  logic [31:0] rdata_next = 32'h0;
  int          age = 0;

  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] rd_log [$];
  logic [31:0] exp_q [$];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_wdata = 32'h0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic [2:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_data;
    int          exp_reads;
    int          exp_writes;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [$];

  assign mem_ack_i = ack_q | late_ack;

  m_dcache #(.SETS(64), .LINE_WORDS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemReadM_i   (MemReadM_i),
    .MemWriteM_i  (MemWriteM_i),
    .ALUResultM_i (ALUResultM_i),
    .WriteDataM_i (WriteDataM_i),
    .ReadDataM_o  (ReadDataM_o),
    .StallAllM_o  (StallAllM_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : a;
  endfunction

  // Backing memory: transaction log, then decide next cycle's ack (ack in 2nd cycle of each request).
  always @(negedge clk) begin
    if (rst_n && mem_req_o && mem_ack_i) begin
      if (mem_we_o) begin
        logic [31:0] w;
        w = rd_word(mem_addr_o);
        for (int b = 0; b < 4; b++) if (mem_be_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        mem_m[mem_addr_o] = w;
        wr_cnt++;
        last_be = mem_be_o;
        last_wdata = mem_wdata_o;
      end else begin
        rd_cnt++;
        rd_log.push_back(mem_addr_o);
      end
    end
    if (!rst_n || ack_q || !mem_req_o) begin
      age = 0;
      ack_next = 1'b0;
    end else begin
      age++;
      ack_next = (age >= ACK_DELAY);
      rdata_next = rd_word(mem_addr_o);
    end
  end

  always @(posedge clk) begin
    ack_q <= ack_next;
    mem_rdata_i <= rdata_next;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic rd, input logic [2:0] we, input logic [31:0] a, input logic [31:0] d,
                         input int st, input logic [31:0] ed, input int nr, input int nw,
                         input logic [3:0] be, input logic [31:0] wd);
    vec_t v;
    v.rd = rd; v.we = we; v.addr = a; v.wdata = d; v.exp_stall = st; v.exp_data = ed;
    v.exp_reads = nr; v.exp_writes = nw; v.exp_be = be; v.exp_wdata = wd;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge; returns just after the edge on which the access retires.
  task automatic do_access(input logic rd, input logic [2:0] we, input logic [31:0] a, input logic [31:0] d,
                           output int stall_n, output logic [31:0] rdata, output logic timeout);
    MemReadM_i = rd; MemWriteM_i = we; ALUResultM_i = a; WriteDataM_i = d;
    stall_n = 0; rdata = 32'h0; timeout = 1'b0;
    while (1) begin
      @(negedge clk);
      if (!StallAllM_o) begin
        rdata = ReadDataM_o;
        break;
      end
      stall_n++;
      if (stall_n > 200) begin
        timeout = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    MemReadM_i = 1'b0; MemWriteM_i = 3'b000;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stall_n, r0, w0;
    logic [31:0] rdata, exp_d;
    logic        tmo, is_ld;

    rst_n = 1'b0; MemReadM_i = 1'b1; MemWriteM_i = 3'b000;
    ALUResultM_i = 32'h104; WriteDataM_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", {31'h0, StallAllM_o}, 32'h0);
    chk("reset_rdata", ReadDataM_o, 32'h0);
    chk("reset_req", {31'h0, mem_req_o}, 32'h0);
    chk("reset_we", {31'h0, mem_we_o}, 32'h0);
    chk("reset_be", {28'h0, mem_be_o}, 32'h0);
    chk("reset_addr", mem_addr_o, 32'h0);
    chk("reset_wdata", mem_wdata_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; MemReadM_i = 1'b0;

    add_vec(1, 3'b000, 32'h104,  32'h0,        9, 32'h0000_0104, 4, 0, 4'h0,    32'h0);
    add_vec(1, 3'b000, 32'h10C,  32'h0,        0, 32'h0000_010C, 0, 0, 4'h0,    32'h0);
    add_vec(0, 3'b001, 32'h106,  32'hAB,       2, 32'h0,         0, 1, 4'b0100, 32'hABAB_ABAB);
    add_vec(1, 3'b000, 32'h104,  32'h0,        0, 32'h00AB_0104, 0, 0, 4'h0,    32'h0);
    add_vec(0, 3'b011, 32'h2000, 32'hDEADBEEF, 2, 32'h0,         0, 1, 4'b1111, 32'hDEAD_BEEF);
    add_vec(1, 3'b000, 32'h2000, 32'h0,        9, 32'hDEAD_BEEF, 4, 0, 4'h0,    32'h0);
    add_vec(1, 3'b000, 32'h104,  32'h0,        0, 32'h00AB_0104, 0, 0, 4'h0,    32'h0);
    add_vec(1, 3'b000, 32'h1104, 32'h0,        9, 32'h0000_1104, 4, 0, 4'h0,    32'h0);
    add_vec(1, 3'b000, 32'h104,  32'h0,        9, 32'h00AB_0104, 4, 0, 4'h0,    32'h0);
    add_vec(0, 3'b010, 32'h10F,  32'h1234,     2, 32'h0,         0, 1, 4'b1100, 32'h1234_1234);
    add_vec(1, 3'b000, 32'h10C,  32'h0,        0, 32'h1234_010C, 0, 0, 4'h0,    32'h0);
    add_vec(1, 3'b011, 32'h10A,  32'h55,       2, 32'h0,         0, 1, 4'b1111, 32'h0000_0055);
    add_vec(1, 3'b000, 32'h108,  32'h0,        0, 32'h0000_0055, 0, 0, 4'h0,    32'h0);
    add_vec(1, 3'b100, 32'h100,  32'h0,        0, 32'h0000_0100, 0, 0, 4'h0,    32'h0);

    foreach (vecs[i]) begin
      r0 = rd_cnt; w0 = wr_cnt;
      rd_log.delete();
      is_ld = vecs[i].rd && !(vecs[i].we inside {3'b001, 3'b010, 3'b011});
      if (is_ld) exp_q.push_back(vecs[i].exp_data);
      do_access(vecs[i].rd, vecs[i].we, vecs[i].addr, vecs[i].wdata, stall_n, rdata, tmo);
      chk($sformatf("v%0d_timeout", i), {31'h0, tmo}, 32'h0);
      chk($sformatf("v%0d_stall", i), stall_n, vecs[i].exp_stall);
      if (is_ld) begin
        if (exp_q.size() > 0) begin
          exp_d = exp_q.pop_front();
          chk($sformatf("v%0d_rdata", i), rdata, exp_d);
        end else begin
          chk($sformatf("v%0d_sb_empty", i), 32'h1, 32'h0);
        end
      end
      chk($sformatf("v%0d_reads", i), rd_cnt - r0, vecs[i].exp_reads);
      chk($sformatf("v%0d_writes", i), wr_cnt - w0, vecs[i].exp_writes);
      if (vecs[i].exp_writes > 0) begin
        chk($sformatf("v%0d_be", i), {28'h0, last_be}, {28'h0, vecs[i].exp_be});
        chk($sformatf("v%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
      end
      if (vecs[i].exp_reads == 4 && rd_log.size() == 4) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("v%0d_raddr%0d", i, k), rd_log[k], (vecs[i].addr & 32'hFFFF_FFF0) + 32'(4 * k));
      end
    end

    // Reset arriving during the second refill word.
    r0 = rd_cnt;
    MemReadM_i = 1'b1; ALUResultM_i = 32'h3000;
    for (int n = 0; n < 50 && rd_cnt < r0 + 1; n++) @(negedge clk);
    chk("rst_first_word", rd_cnt - r0, 1);
    @(posedge clk);
    #1;
    chk("rst_mid_req", {31'h0, mem_req_o}, 32'h1);
    chk("rst_mid_addr", mem_addr_o, 32'h3004);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req_drop", {31'h0, mem_req_o}, 32'h0);
    chk("rst_addr_clr", mem_addr_o, 32'h0);
    chk("rst_stall_low", {31'h0, StallAllM_o}, 32'h0);
    chk("rst_rdata_zero", ReadDataM_o, 32'h0);
    rst_n = 1'b1; MemReadM_i = 1'b0;
    late_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_stall", {31'h0, StallAllM_o}, 32'h0);
    chk("late_ack_req", {31'h0, mem_req_o}, 32'h0);
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    chk("late_ack_noread", rd_cnt - r0, 1);

    exp_q.push_back(32'h0000_3000);
    do_access(1, 3'b000, 32'h3000, 32'h0, stall_n, rdata, tmo);
    chk("post_rst_stall", stall_n, 9);
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk("post_rst_rdata", rdata, exp_d);
    exp_q.push_back(32'h1234_010C);
    do_access(1, 3'b000, 32'h10C, 32'h0, stall_n, rdata, tmo);
    chk("post_rst_cold_stall", stall_n, 9);
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk("post_rst_cold_rdata", rdata, exp_d);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
